// File: rtl/surf_dout_framer.sv
// SURF-side DOUT link framer.
// Produces one byte per sysclk for the OSERDES wrapper. Each byte is either
// idle (8'h00), the 32-bit training word (MSB byte first), or part of a
// fixed-length event frame: SOF, frame count, FRAME_BYTES payload bytes and
// an XOR checksum. dout_o is registered, so the byte chosen while in a
// state appears one cycle later.
module surf_dout_framer #(
    parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
    parameter int unsigned FRAME_BYTES    = 64,
    parameter logic [7:0]  SOF_BYTE       = 8'h01
) (
    input  logic       sysclk_i,
    input  logic       rst_i,
    input  logic       train_i,
    input  logic       sync_i,
    input  logic [7:0] s_dout_tdata,
    input  logic       s_dout_tvalid,
    output logic       s_dout_tready,
    input  logic       s_dout_tlast,
    input  logic       err_clear_i,
    output logic [7:0] dout_o,
    output logic       busy_o,
    output logic       underflow_o,
    output logic       tlast_err_o,
    output logic [7:0] frame_count_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRAIN   = 3'd1,
        ST_SOF     = 3'd2,
        ST_CNT     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CKSUM   = 3'd5
    } state_t;

    // Payload counter value of the final payload byte.
    localparam logic [15:0] LAST_IDX = 16'(FRAME_BYTES - 1);

    // Selects one byte of the training word; idx 0 is the MSB byte.
    function automatic logic [7:0] f_train_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = TRAIN_SEQUENCE[31:24];
            2'd1:    b = TRAIN_SEQUENCE[23:16];
            2'd2:    b = TRAIN_SEQUENCE[15:8];
            2'd3:    b = TRAIN_SEQUENCE[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Running XOR checksum update.
    function automatic logic [7:0] f_cksum(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_idx;
    logic [15:0] r_pcnt;
    logic [15:0] w_pcnt_next;
    logic [7:0]  r_cksum;
    logic [7:0]  w_cksum_next;
    logic [7:0]  r_fcnt;
    logic [7:0]  w_fcnt_next;
    logic [7:0]  r_dout;
    logic [7:0]  w_byte;
    logic        r_drop;
    logic        w_drop_next;
    logic        r_underflow;
    logic        r_tlast_err;
    logic        w_uf_set;
    logic        w_tl_set;
    logic        w_tready;
    logic        w_accept;
    logic        w_last_beat;

    // After an early tlast the rest of the frame is padded, so tready is
    // withheld until the next frame starts.
    assign w_tready    = (r_state == ST_PAYLOAD) && !r_drop;
    assign w_accept    = w_tready && s_dout_tvalid;
    assign w_last_beat = (r_pcnt == LAST_IDX);

    assign s_dout_tready = w_tready;
    assign busy_o        = (r_state != ST_IDLE);
    assign dout_o        = r_dout;
    assign underflow_o   = r_underflow;
    assign tlast_err_o   = r_tlast_err;
    assign frame_count_o = r_fcnt;

    // Next-state, byte selection and datapath updates.
    always_comb begin
        w_next_state = r_state;
        w_byte       = 8'h00;
        w_pcnt_next  = r_pcnt;
        w_cksum_next = r_cksum;
        w_fcnt_next  = r_fcnt;
        w_drop_next  = r_drop;
        w_uf_set     = 1'b0;
        w_tl_set     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_byte = 8'h00;
                if (train_i && (r_idx == 2'd0)) begin
                    w_next_state = ST_TRAIN;
                end else if (!train_i && s_dout_tvalid) begin
                    w_next_state = ST_SOF;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_TRAIN: begin
                w_byte = f_train_byte(r_idx);
                // Leave only after byte 3 so the word is never truncated.
                if (!train_i && (r_idx == 2'd3)) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_TRAIN;
                end
            end
            ST_SOF: begin
                w_byte       = SOF_BYTE;
                w_pcnt_next  = 16'd0;
                w_drop_next  = 1'b0;
                w_next_state = ST_CNT;
            end
            ST_CNT: begin
                w_byte       = r_fcnt;
                w_cksum_next = r_fcnt;
                w_next_state = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (w_accept) begin
                    w_byte = s_dout_tdata;
                end else begin
                    w_byte = 8'h00;
                end
                w_cksum_next = f_cksum(r_cksum, w_byte);
                // Starvation: the frame length is kept, a zero is sent.
                w_uf_set = w_tready && !s_dout_tvalid;
                if (w_accept && s_dout_tlast && !w_last_beat) begin
                    w_tl_set    = 1'b1;
                    w_drop_next = 1'b1;
                end else if (w_accept && !s_dout_tlast && w_last_beat) begin
                    w_tl_set = 1'b1;
                end else begin
                    w_tl_set = 1'b0;
                end
                if (w_last_beat) begin
                    w_next_state = ST_CKSUM;
                end else begin
                    w_pcnt_next  = r_pcnt + 16'd1;
                    w_next_state = ST_PAYLOAD;
                end
            end
            ST_CKSUM: begin
                w_byte       = r_cksum;
                w_fcnt_next  = r_fcnt + 8'd1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_byte       = 8'h00;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; sticky flags favour set over clear.
    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_pcnt      <= 16'd0;
            r_cksum     <= 8'h00;
            r_fcnt      <= 8'h00;
            r_dout      <= 8'h00;
            r_drop      <= 1'b0;
            r_underflow <= 1'b0;
            r_tlast_err <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_idx       <= sync_i ? 2'd0 : (r_idx + 2'd1);
            r_pcnt      <= w_pcnt_next;
            r_cksum     <= w_cksum_next;
            r_fcnt      <= w_fcnt_next;
            r_dout      <= w_byte;
            r_drop      <= w_drop_next;
            r_underflow <= w_uf_set | (r_underflow & ~err_clear_i);
            r_tlast_err <= w_tl_set | (r_tlast_err & ~err_clear_i);
        end
    end

endmodule

// File: tb/tb_surf_dout_framer.sv
// Scoreboard bench for surf_dout_framer with FRAME_BYTES = 4.
// Stimulus pushes expected values tagged with the cycle they must appear in;
// a monitor on the falling edge pops and compares them.
module tb_surf_dout_framer;

    localparam int K_DOUT = 0;
    localparam int K_RDY  = 1;
    localparam int K_BUSY = 2;
    localparam int K_UF   = 3;
    localparam int K_TL   = 4;
    localparam int K_FC   = 5;

    logic       sysclk_i = 1'b0;
    logic       rst_i    = 1'b1;
    logic       train_i  = 1'b0;
    logic       sync_i   = 1'b0;
    logic [7:0] s_dout_tdata  = 8'h00;
    logic       s_dout_tvalid = 1'b0;
    logic       s_dout_tready;
    logic       s_dout_tlast  = 1'b0;
    logic       err_clear_i   = 1'b0;
    logic [7:0] dout_o;
    logic       busy_o;
    logic       underflow_o;
    logic       tlast_err_o;
    logic [7:0] frame_count_o;

    surf_dout_framer #(
        .TRAIN_SEQUENCE(32'hA55A6996),
        .FRAME_BYTES   (4),
        .SOF_BYTE      (8'h01)
    ) dut (
        .sysclk_i     (sysclk_i),
        .rst_i        (rst_i),
        .train_i      (train_i),
        .sync_i       (sync_i),
        .s_dout_tdata (s_dout_tdata),
        .s_dout_tvalid(s_dout_tvalid),
        .s_dout_tready(s_dout_tready),
        .s_dout_tlast (s_dout_tlast),
        .err_clear_i  (err_clear_i),
        .dout_o       (dout_o),
        .busy_o       (busy_o),
        .underflow_o  (underflow_o),
        .tlast_err_o  (tlast_err_o),
        .frame_count_o(frame_count_o)
    );

    always #5 sysclk_i = ~sysclk_i;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Count rising edges so expectations can name the cycle they belong to.
    always @(posedge sysclk_i) cyc <= cyc + 1;

    function automatic logic [7:0] sample(input int kind);
        logic [7:0] v;
        case (kind)
            K_DOUT:  v = dout_o;
            K_RDY:   v = {7'd0, s_dout_tready};
            K_BUSY:  v = {7'd0, busy_o};
            K_UF:    v = {7'd0, underflow_o};
            K_TL:    v = {7'd0, tlast_err_o};
            K_FC:    v = frame_count_o;
            default: v = 8'hxx;
        endcase
        return v;
    endfunction

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge sysclk_i) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                logic [7:0] act;
                act = sample(q[i].kind);
                n_checks++;
                if ((q[i].cyc < cyc) || (act !== q[i].val)) begin
                    n_fail++;
                    $display("FAIL %s: cycle %0d actual %h expected %h (due cycle %0d)",
                             q[i].name, cyc, act, q[i].val, q[i].cyc);
                end
                q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge sysclk_i);
        #1;
    endtask

    task automatic push(input int offs, input int kind, input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + offs;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    function automatic logic [7:0] train_byte(input int i);
        logic [7:0] b;
        case (i)
            0:       b = 8'hA5;
            1:       b = 8'h5A;
            2:       b = 8'h69;
            3:       b = 8'h96;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // One 4-byte frame starting in an IDLE cycle; returns in the IDLE cycle
    // after the checksum has been chosen. Bytes are packed MSB = byte 0.
    task automatic run_frame(input logic [31:0] d, input logic [3:0] vm, input int tl_pos,
                             input logic [31:0] sent, input logic [3:0] rdy,
                             input logic [7:0] fc, input logic [7:0] ck, input int clr_at);
        train_i       = 1'b0;
        s_dout_tvalid = 1'b1;
        s_dout_tdata  = d[31:24];
        s_dout_tlast  = 1'b0;
        push(1, K_DOUT, 8'h00, "idle_gap");
        tick();
        push(1, K_DOUT, 8'h01, "sof");
        tick();
        push(1, K_DOUT, fc, "cnt");
        tick();
        for (int p = 0; p < 4; p++) begin
            s_dout_tdata  = d[31-8*p -: 8];
            s_dout_tvalid = vm[3-p];
            s_dout_tlast  = (p == tl_pos);
            err_clear_i   = (p == clr_at);
            push(1, K_DOUT, sent[31-8*p -: 8], "payload");
            push(0, K_RDY, {7'd0, rdy[3-p]}, "tready");
            tick();
        end
        s_dout_tvalid = 1'b0;
        s_dout_tlast  = 1'b0;
        err_clear_i   = 1'b0;
        push(1, K_DOUT, ck, "cksum");
        push(0, K_BUSY, 8'h01, "busy_cksum");
        tick();
        push(0, K_FC, fc + 8'd1, "frame_count");
    endtask

    task automatic clear_errs();
        err_clear_i = 1'b1;
        tick();
        err_clear_i = 1'b0;
        push(0, K_UF, 8'h00, "uf_cleared");
        push(0, K_TL, 8'h00, "tl_cleared");
    endtask

    initial begin
        // Reset state.
        rst_i = 1'b1;
        repeat (3) tick();
        push(0, K_DOUT, 8'h00, "rst_dout");
        push(0, K_RDY,  8'h00, "rst_tready");
        push(0, K_BUSY, 8'h00, "rst_busy");
        push(0, K_UF,   8'h00, "rst_uf");
        push(0, K_TL,   8'h00, "rst_tl");
        push(0, K_FC,   8'h00, "rst_fc");
        rst_i = 1'b0;
        tick();

        // Training: sync, hold train, drop it while byte 1 is being sent.
        sync_i = 1'b1;
        tick();
        sync_i  = 1'b0;
        train_i = 1'b1;
        push(1, K_DOUT, 8'h00, "train_entry_idle");
        for (int j = 0; j < 7; j++) begin
            tick();
            if (j == 4) train_i = 1'b0;
            push(1, K_DOUT, train_byte((j + 1) % 4), "train_byte");
            push(0, K_BUSY, 8'h01, "train_busy");
        end
        tick();
        push(1, K_DOUT, 8'h00, "train_exit_idle");
        push(0, K_BUSY, 8'h00, "train_exit_busy");

        // Priority: train and tvalid together in IDLE enter TRAIN.
        sync_i = 1'b1;
        tick();
        sync_i        = 1'b0;
        train_i       = 1'b1;
        s_dout_tvalid = 1'b1;
        s_dout_tdata  = 8'h77;
        push(1, K_DOUT, 8'h00, "prio_idle");
        tick();
        train_i = 1'b0;
        push(1, K_DOUT, 8'h5A, "prio_train1");
        tick();
        push(1, K_DOUT, 8'h69, "prio_train2");
        tick();
        s_dout_tvalid = 1'b0;
        push(1, K_DOUT, 8'h96, "prio_train3");
        tick();
        push(1, K_DOUT, 8'h00, "prio_back_idle");
        push(0, K_BUSY, 8'h00, "prio_busy");

        // Mid-frame reset abandons the frame.
        s_dout_tvalid = 1'b1;
        s_dout_tdata  = 8'h11;
        push(1, K_DOUT, 8'h00, "mr_idle");
        tick();
        push(1, K_DOUT, 8'h01, "mr_sof");
        tick();
        push(1, K_DOUT, 8'h00, "mr_cnt");
        tick();
        push(1, K_DOUT, 8'h11, "mr_p0");
        push(0, K_RDY, 8'h01, "mr_tready");
        tick();
        s_dout_tdata = 8'h22;
        rst_i        = 1'b1;
        tick();
        rst_i         = 1'b0;
        s_dout_tvalid = 1'b0;
        push(0, K_DOUT, 8'h00, "mr_dout");
        push(0, K_FC,   8'h00, "mr_fc");
        push(0, K_RDY,  8'h00, "mr_tready_low");
        push(0, K_BUSY, 8'h00, "mr_busy");
        tick();
        push(0, K_DOUT, 8'h00, "mr_no_cksum");

        // Clean frame: checksum 00^11^22^33^44 = 44.
        run_frame(32'h11223344, 4'b1111, 3, 32'h11223344, 4'b1111, 8'h00, 8'h44, -1);
        push(0, K_UF, 8'h00, "f0_uf");
        push(0, K_TL, 8'h00, "f0_tl");

        // Starvation on byte 3, with err_clear in the same cycle (set wins).
        run_frame(32'h11223344, 4'b1101, 3, 32'h11220044, 4'b1111, 8'h01, 8'h76, 2);
        push(0, K_UF, 8'h01, "f1_uf");
        push(0, K_TL, 8'h00, "f1_tl");
        clear_errs();

        // Early tlast on byte 2: pad, tready low, no underflow.
        run_frame(32'h11223344, 4'b1111, 1, 32'h11220000, 4'b1100, 8'h02, 8'h31, -1);
        push(0, K_UF, 8'h00, "f2_uf");
        push(0, K_TL, 8'h01, "f2_tl");
        clear_errs();

        // Final byte without tlast.
        run_frame(32'hAABBCCDD, 4'b1111, 4, 32'hAABBCCDD, 4'b1111, 8'h03, 8'h03, -1);
        push(0, K_TL, 8'h01, "f3_tl");
        clear_errs();

        // Next frame starts directly with the next stream bytes.
        run_frame(32'h01020304, 4'b1111, 3, 32'h01020304, 4'b1111, 8'h04, 8'h00, -1);
        push(0, K_TL, 8'h00, "f4_tl");

        // Run up to 256 completed frames; frame count wraps to 0.
        for (int f = 5; f < 256; f++) begin
            run_frame(32'h11223344, 4'b1111, 3, 32'h11223344, 4'b1111,
                      8'(f), 8'(f) ^ 8'h44, -1);
        end
        push(0, K_FC, 8'h00, "wrap_fc");
        run_frame(32'h11223344, 4'b1111, 3, 32'h11223344, 4'b1111, 8'h00, 8'h44, -1);

        repeat (3) tick();
        if (q.size() != 0) begin
            $display("FAIL scoreboard_drain: actual %0d pending expected 0", q.size());
            n_fail = n_fail + q.size();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
